// File: rtl/cp_pkg.sv
// Shared RV32I encodings used by the write-back stage and its load aligner.
package cp_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/cp_wb_stage_if.sv
// Memory-stage to write-back-stage bundle.
// Handshake: a transfer happens on a rising edge where valid_mem_i & ready_mem_o;
// the master holds its fields stable while valid_mem_i is high and ready_mem_o is low.
interface cp_wb_stage_if;

    logic        valid_mem_i;
    logic        ready_mem_o;
    logic [31:0] rs1_data_mem_i;
    logic [31:0] rs2_data_mem_i;
    logic        rd_we_mem_i;
    logic [4:0]  rd_addr_mem_i;
    logic [2:0]  func3_mem_i;
    logic [6:0]  opcode_mem_i;
    logic [31:0] rdata_mem_i;

    modport master (
        output valid_mem_i, rs1_data_mem_i, rs2_data_mem_i, rd_we_mem_i,
               rd_addr_mem_i, func3_mem_i, opcode_mem_i, rdata_mem_i,
        input  ready_mem_o
    );

    modport slave (
        input  valid_mem_i, rs1_data_mem_i, rs2_data_mem_i, rd_we_mem_i,
               rd_addr_mem_i, func3_mem_i, opcode_mem_i, rdata_mem_i,
        output ready_mem_o
    );

endinterface

// File: rtl/cp_load_align.sv
// Load lane select, sign/zero extension and misalignment detection.
module cp_load_align
    import cp_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data,
    output logic        o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Data is forced to zero whenever the access is flagged as an error.
    always_comb begin
        o_data = 32'd0;
        o_err  = 1'b0;
        case (i_func3)
            F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU: o_data = {24'd0, w_byte};
            F3_LH: begin
                if (i_addr[0]) o_err = 1'b1;
                else           o_data = {{16{w_half[15]}}, w_half};
            end
            F3_LHU: begin
                if (i_addr[0]) o_err = 1'b1;
                else           o_data = {16'd0, w_half};
            end
            F3_LW: begin
                if (i_addr != 2'd0) o_err = 1'b1;
                else                o_data = i_rdata;
            end
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/cp_wb_stage.sv
// Single-entry write-back stage: aligns load data, writes the register file,
// drives the bypass path and counts retired instructions.
module cp_wb_stage
    import cp_pkg::*;
#(
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    cp_wb_stage_if.slave         mem,
    output logic                 rf_we_o,
    output logic [4:0]           rf_addr_o,
    output logic [31:0]          rf_data_o,
    input  logic                 rf_ready_i,
    output logic                 fwd_valid_o,
    output logic [4:0]           fwd_addr_o,
    output logic [31:0]          fwd_data_o,
    output logic                 err_o,
    output logic [INSTRET_W-1:0] instret_o
);

    logic                 r_valid;
    logic                 r_rd_we;
    logic [4:0]           r_rd_addr;
    logic [31:0]          r_data;
    logic                 r_err;
    logic [INSTRET_W-1:0] r_instret;

    logic        w_is_load;
    logic        w_accept;
    logic        w_retire;
    logic [31:0] w_align_data;
    logic        w_align_err;
    logic        w_err;
    logic [31:0] w_data;
    logic        w_unused_rs2;

    cp_load_align u_align (
        .i_func3 (mem.func3_mem_i),
        .i_addr  (mem.rs1_data_mem_i[1:0]),
        .i_rdata (mem.rdata_mem_i),
        .o_data  (w_align_data),
        .o_err   (w_align_err)
    );

    // Store data travels with the instruction but has no use at write-back.
    assign w_unused_rs2 = ^mem.rs2_data_mem_i;

    assign w_is_load       = (mem.opcode_mem_i == OP_LOAD);
    assign mem.ready_mem_o = ~r_valid | rf_ready_i;
    assign w_accept        = mem.valid_mem_i & mem.ready_mem_o;
    assign w_retire        = r_valid & rf_ready_i;
    assign w_err           = w_is_load & w_align_err;
    assign w_data          = w_err ? 32'd0 : (w_is_load ? w_align_data : mem.rs1_data_mem_i);

    // When the slot is empty or draining, it refills from this cycle's accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_rd_we   <= 1'b0;
            r_rd_addr <= 5'd0;
            r_data    <= 32'd0;
            r_err     <= 1'b0;
            r_instret <= '0;
        end else begin
            if (mem.ready_mem_o) begin
                r_valid <= w_accept;
            end
            if (w_accept) begin
                r_rd_we   <= mem.rd_we_mem_i & ~w_err;
                r_rd_addr <= mem.rd_addr_mem_i;
                r_data    <= w_data;
                r_err     <= w_err;
            end
            if (w_retire) begin
                r_instret <= r_instret + INSTRET_W'(1);
            end
        end
    end

    assign rf_we_o     = r_valid & r_rd_we & (r_rd_addr != 5'd0);
    assign rf_addr_o   = r_rd_addr;
    assign rf_data_o   = r_data;
    assign fwd_valid_o = rf_we_o;
    assign fwd_addr_o  = rf_addr_o;
    assign fwd_data_o  = rf_data_o;
    assign err_o       = r_valid & r_err & rf_ready_i;
    assign instret_o   = r_instret;

endmodule

// File: tb/tb_cp_wb_stage.sv
// Directed bench for cp_wb_stage: load alignment, errors, x0 suppression,
// stall/back-to-back flow and reset of a held entry.
module tb_cp_wb_stage;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_ALU   = 7'b0110011;

    logic        clk;
    logic        rst;
    logic        rf_we_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;
    logic        rf_ready_i;
    logic        fwd_valid_o;
    logic [4:0]  fwd_addr_o;
    logic [31:0] fwd_data_o;
    logic        err_o;
    logic [63:0] instret_o;

    int n_checks;
    int n_pass;

    cp_wb_stage_if mem_if ();

    cp_wb_stage #(.INSTRET_W(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (mem_if),
        .rf_we_o     (rf_we_o),
        .rf_addr_o   (rf_addr_o),
        .rf_data_o   (rf_data_o),
        .rf_ready_i  (rf_ready_i),
        .fwd_valid_o (fwd_valid_o),
        .fwd_addr_o  (fwd_addr_o),
        .fwd_data_o  (fwd_data_o),
        .err_o       (err_o),
        .instret_o   (instret_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] rs1,
                             input logic [31:0] rdata, input logic we, input logic [4:0] rd);
        mem_if.opcode_mem_i   = op;
        mem_if.func3_mem_i    = f3;
        mem_if.rs1_data_mem_i = rs1;
        mem_if.rs2_data_mem_i = $urandom;
        mem_if.rdata_mem_i    = rdata;
        mem_if.rd_we_mem_i    = we;
        mem_if.rd_addr_mem_i  = rd;
        mem_if.valid_mem_i    = 1'b1;
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] rs1,
                        input logic [31:0] rdata, input logic we, input logic [4:0] rd);
        set_instr(op, f3, rs1, rdata, we, rd);
        tick();
        mem_if.valid_mem_i = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        rf_ready_i = 1'b1;
        mem_if.valid_mem_i = 1'b0;
        set_instr(OPC_ALU, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        mem_if.valid_mem_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_we", rf_we_o, 0);
        check("rst_fwd_valid", fwd_valid_o, 0);
        check("rst_err", err_o, 0);
        check("rst_instret", instret_o, 0);
        check("rst_ready", mem_if.ready_mem_o, 1);

        send(OPC_LOAD, 3'd0, 32'h0000_1003, 32'h80FF_0000, 1'b1, 5'd5);
        check("lb_we", rf_we_o, 1);
        check("lb_addr", rf_addr_o, 5);
        check("lb_data", rf_data_o, 32'hFFFF_FF80);
        check("lb_fwd_data", fwd_data_o, 32'hFFFF_FF80);
        check("lb_fwd_addr", fwd_addr_o, 5);
        check("lb_err", err_o, 0);
        check("lb_instret_pre", instret_o, 0);
        tick();
        check("lb_instret", instret_o, 1);
        check("idle_we", rf_we_o, 0);

        send(OPC_LOAD, 3'd5, 32'h0000_2002, 32'hBEEF_1234, 1'b1, 5'd6);
        check("lhu_data", rf_data_o, 32'h0000_BEEF);
        check("lhu_instret", instret_o, 1);
        send(OPC_LOAD, 3'd1, 32'h0000_2002, 32'hBEEF_1234, 1'b1, 5'd7);
        check("lh_data", rf_data_o, 32'hFFFF_BEEF);
        check("lh_we", rf_we_o, 1);
        check("b2b_instret", instret_o, 2);
        tick();
        check("lh_instret", instret_o, 3);

        send(OPC_LOAD, 3'd2, 32'h0000_3001, 32'h1122_3344, 1'b1, 5'd8);
        check("lw_mis_we", rf_we_o, 0);
        check("lw_mis_err", err_o, 1);
        check("lw_mis_data", rf_data_o, 0);
        tick();
        check("lw_mis_err_pulse", err_o, 0);
        check("lw_mis_instret", instret_o, 4);

        send(OPC_LOAD, 3'd3, 32'h0000_3000, 32'h1122_3344, 1'b1, 5'd8);
        check("f3_rsvd_err", err_o, 1);
        check("f3_rsvd_we", rf_we_o, 0);
        tick();
        check("f3_rsvd_instret", instret_o, 5);

        send(OPC_ALU, 3'd0, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 5'd0);
        check("x0_we", rf_we_o, 0);
        check("x0_fwd_valid", fwd_valid_o, 0);
        check("alu_data", rf_data_o, 32'h1234_5678);
        tick();
        check("x0_instret", instret_o, 6);

        send(OPC_ALU, 3'd0, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 5'd7);
        set_instr(OPC_ALU, 3'd0, 32'hAAAA_0001, 32'h0, 1'b1, 5'd8);
        rf_ready_i = 1'b0;
        #1;
        check("stall_ready", mem_if.ready_mem_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_we", rf_we_o, 1);
            check("stall_addr", rf_addr_o, 7);
            check("stall_data", rf_data_o, 32'h1234_5678);
            check("stall_instret", instret_o, 6);
            check("stall_ready_hold", mem_if.ready_mem_o, 0);
        end
        rf_ready_i = 1'b1;
        #1;
        check("unstall_ready", mem_if.ready_mem_o, 1);
        tick();
        check("b2b1_addr", rf_addr_o, 8);
        check("b2b1_data", rf_data_o, 32'hAAAA_0001);
        check("b2b1_instret", instret_o, 7);
        set_instr(OPC_ALU, 3'd0, 32'hBBBB_0002, 32'h0, 1'b1, 5'd9);
        tick();
        mem_if.valid_mem_i = 1'b0;
        check("b2b2_addr", rf_addr_o, 9);
        check("b2b2_data", rf_data_o, 32'hBBBB_0002);
        check("b2b2_instret", instret_o, 8);
        tick();
        check("b2b_drain_instret", instret_o, 9);
        check("b2b_drain_we", rf_we_o, 0);

        send(OPC_STORE, 3'd2, 32'h0000_0100, 32'h0, 1'b0, 5'd0);
        check("store_we", rf_we_o, 0);
        check("store_err", err_o, 0);
        tick();
        check("store_instret", instret_o, 10);

        send(OPC_LOAD, 3'd4, 32'h0000_1001, 32'h1234_80FF, 1'b1, 5'd6);
        check("lbu_data", rf_data_o, 32'h0000_0080);
        check("lbu_we", rf_we_o, 1);
        tick();
        check("lbu_instret", instret_o, 11);

        send(OPC_LOAD, 3'd1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 5'd6);
        check("lh_mis_err", err_o, 1);
        check("lh_mis_data", rf_data_o, 0);
        tick();
        check("lh_mis_instret", instret_o, 12);

        send(OPC_ALU, 3'd0, 32'hCAFE_0003, 32'h0, 1'b1, 5'd3);
        rf_ready_i = 1'b0;
        tick();
        check("rst_stall_we", rf_we_o, 1);
        check("rst_stall_instret", instret_o, 12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_we", rf_we_o, 0);
        check("rst_mid_fwd", fwd_valid_o, 0);
        check("rst_mid_err", err_o, 0);
        check("rst_mid_instret", instret_o, 0);
        check("rst_mid_ready", mem_if.ready_mem_o, 1);
        rf_ready_i = 1'b1;
        tick();
        check("rst_mid_no_count", instret_o, 0);
        check("rst_mid_no_write", rf_we_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cp_wb_stage.md
CP_WB_STAGE -- requirements
Module: cp_wb_stage

Interface
REQ-001 Parameter: INSTRET_W, 64, width of the retired-instruction counter.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 valid_mem_i  in  1  memory stage holds a valid instruction.
REQ-006 ready_mem_o  out  1  this stage accepts the offered instruction this cycle.
REQ-007 rs1_data_mem_i  in  32  load: effective byte address; non-load: ALU result.
REQ-008 rs2_data_mem_i  in  32  store data, carried but unused except by the bench.
REQ-009 rd_we_mem_i  in  1  instruction writes rd.
REQ-010 rd_addr_mem_i  in  5  destination register.
REQ-011 func3_mem_i  in  3  RV32I func3.
REQ-012 opcode_mem_i  in  7  RV32I opcode.
REQ-013 rdata_mem_i  in  32  raw aligned data-memory word.
REQ-014 rf_we_o  out  1  register-file write enable.
REQ-015 rf_addr_o  out  5  register-file write address.
REQ-016 rf_data_o  out  32  register-file write data.
REQ-017 rf_ready_i  in  1  register file accepts the write this cycle.
REQ-018 fwd_valid_o  out  1  bypass value valid (equals rf_we_o).
REQ-019 fwd_addr_o  out  5  bypass register (equals rf_addr_o).
REQ-020 fwd_data_o  out  32  bypass data (equals rf_data_o).
REQ-021 err_o  out  1  one-cycle pulse: misaligned load or reserved load func3 retired.
REQ-022 instret_o  out  INSTRET_W  count of retired instructions.

Function
REQ-023 Stage SHALL hold one entry (valid_q plus registered rd_we, rd_addr, data, err).
REQ-024 ready_mem_o SHALL equal ~valid_q | rf_ready_i (combinational, no dependency on valid_mem_i).
REQ-025 Accept occurs when valid_mem_i & ready_mem_o; captured fields SHALL appear on outputs the next cycle (latency 1).
REQ-026 Retire occurs when valid_q & rf_ready_i; valid_q SHALL then load the accept condition of the same cycle (simultaneous retire+accept keeps valid_q=1, no bubble).
REQ-027 Load (opcode 0000011) data SHALL be selected by addr[1:0]: LB/LBU byte lane addr[1:0], LH/LHU half lane addr[1], LW whole word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-028 Non-load data SHALL be rs1_data_mem_i unchanged.
REQ-029 Misaligned load (LH/LHU addr[0]=1; LW addr[1:0]!=0) or load func3 in {3,6,7} SHALL set err_q, force data to 0 and clear captured rd_we.
REQ-030 rf_we_o SHALL be valid_q & rd_we_q & (rd_addr_q != 0); x0 writes never issued.
REQ-031 err_o SHALL be valid_q & err_q & rf_ready_i (asserted only in the retire cycle).
REQ-032 instret SHALL increment by 1 on every retire, including stores, branches and errored loads; wraps modulo 2^INSTRET_W.
REQ-033 While valid_q & ~rf_ready_i, all outputs SHALL stay stable.

Reset
REQ-034 rst SHALL clear valid_q, rd_we_q, err_q, rd_addr_q, data_q and instret to 0; rf_we_o, fwd_valid_o, err_o =0 the cycle after.
REQ-035 rst asserted mid-stall SHALL discard the held entry with no write and no count.
REQ-036 ready_mem_o SHALL be 1 the cycle after reset.

Structure
REQ-037 Opcode constants (OP_LOAD, OP_STORE) and load func3 encodings (LB, LH, LW, LBU, LHU) SHALL live in shared package cp_pkg.
REQ-038 Lane select, extension and misalignment check SHALL be a combinational sub-module cp_load_align.

Verification
REQ-039 LB addr=0x1003, rdata=0x80FF_0000 -> rf_data_o=0xFFFF_FF80, rf_we_o=1 next cycle.
REQ-040 LHU addr=0x2002, rdata=0xBEEF_1234 -> rf_data_o=0x0000_BEEF; LH same -> 0xFFFF_BEEF.
REQ-041 LW addr=0x3001 -> rf_we_o=0, err_o=1 for one cycle, instret +1.
REQ-042 rf_ready_i=0 for 3 cycles with valid_mem_i=1 -> ready_mem_o=0, outputs frozen, instret unchanged; then back-to-back accepts with rf_ready_i=1 -> one retire per cycle.
REQ-043 ALU result 0x1234_5678 to rd=0, rd_we=1 -> rf_we_o=0, instret +1.
REQ-044 rst during stall with held entry -> no write, instret=0, ready_mem_o=1 next cycle.
